action_controller: RTL

Multi-player character action controller. It turns per-player button vectors into registered action codes: STAND, JUMP, DIVE and RUN. Compared with the single-player action FSM, it adds:
- a parametrised player count;
- rising-edge jump detection;
- a fixed airborne duration with at most one dive per jump;
- a post-landing jump cooldown.

It sits between the button input stage and the sprite/animation logic.

---
 rtl/action_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/action_controller.sv
// action_controller: per-player button vectors -> registered STAND/JUMP/DIVE/RUN codes.
// Each player channel is independent. A jump starts on a rising jump edge, stays airborne
// for JUMP_CYCLES cycles, allows at most one dive, and is followed by a landing cooldown.
// Optional build macro ACTION_STATS_EN adds jump_count_o, a saturating 8-bit count of
// accepted jumps per player.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_STAND | grounded, run not held (action 00)
// ST_JUMP  | airborne, counting down air time (action 01)
// ST_DIVE  | airborne, single dive cycle within a jump (action 10)
// ST_RUN   | grounded, run held (action 11)

module action_controller #(
    parameter int NUM_PLAYERS     = 2,
    parameter int JUMP_CYCLES     = 4,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [3*NUM_PLAYERS-1:0]   buttons_i,
    output logic [2*NUM_PLAYERS-1:0]   action_o,
    output logic [NUM_PLAYERS-1:0]     airborne_o
`ifdef ACTION_STATS_EN
    ,
    output logic [8*NUM_PLAYERS-1:0]   jump_count_o
`endif
);

    localparam int AIR_W  = $clog2(JUMP_CYCLES + 1);
    localparam int COOL_W = ($clog2(COOLDOWN_CYCLES + 1) > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_STAND = 2'b00,
        ST_JUMP  = 2'b01,
        ST_DIVE  = 2'b10,
        ST_RUN   = 2'b11
    } state_t;

    state_t                 state_q    [NUM_PLAYERS];
    state_t                 state_d    [NUM_PLAYERS];
    logic [AIR_W-1:0]       air_cnt_q  [NUM_PLAYERS];
    logic [AIR_W-1:0]       air_cnt_d  [NUM_PLAYERS];
    logic [COOL_W-1:0]      cool_cnt_q [NUM_PLAYERS];
    logic [COOL_W-1:0]      cool_cnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] jmp_q;
    logic [NUM_PLAYERS-1:0] jmp_d;
    logic [NUM_PLAYERS-1:0] dive_used_q;
    logic [NUM_PLAYERS-1:0] dive_used_d;
    logic [NUM_PLAYERS-1:0] jump_acc;

    // Per-channel state register; reset drops any jump in flight with no cooldown.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            jmp_q       <= '0;
            dive_used_q <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state_q[p]    <= ST_STAND;
                air_cnt_q[p]  <= '0;
                cool_cnt_q[p] <= '0;
            end
        end else begin
            jmp_q       <= jmp_d;
            dive_used_q <= dive_used_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state_q[p]    <= state_d[p];
                air_cnt_q[p]  <= air_cnt_d[p];
                cool_cnt_q[p] <= cool_cnt_d[p];
            end
        end
    end

    // Next-state logic: grounded channels look for an accepted jump edge, airborne
    // channels count down air time and land once the counter has reached zero.
    always_comb begin
        jmp_d       = '0;
        dive_used_d = dive_used_q;
        jump_acc    = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            state_d[p]    = state_q[p];
            air_cnt_d[p]  = air_cnt_q[p];
            cool_cnt_d[p] = cool_cnt_q[p];
            jmp_d[p]      = buttons_i[3*p+2];
            case (state_q[p])
                ST_STAND, ST_RUN: begin
                    // Cooldown keeps draining even on a cycle where a jump is refused.
                    if (cool_cnt_q[p] != '0) begin
                        cool_cnt_d[p] = cool_cnt_q[p] - COOL_W'(1);
                    end
                    if (buttons_i[3*p+2] && !jmp_q[p] && (cool_cnt_q[p] == '0)) begin
                        state_d[p]     = ST_JUMP;
                        air_cnt_d[p]   = AIR_W'(JUMP_CYCLES - 1);
                        dive_used_d[p] = 1'b0;
                        jump_acc[p]    = 1'b1;
                    end else if (buttons_i[3*p+1]) begin
                        state_d[p] = ST_RUN;
                    end else begin
                        state_d[p] = ST_STAND;
                    end
                end
                default: begin
                    // Landing wins over a dive request on the last airborne cycle.
                    if (air_cnt_q[p] == '0) begin
                        state_d[p]    = buttons_i[3*p+1] ? ST_RUN : ST_STAND;
                        cool_cnt_d[p] = COOL_W'(COOLDOWN_CYCLES);
                    end else begin
                        air_cnt_d[p] = air_cnt_q[p] - AIR_W'(1);
                        if ((state_q[p] == ST_JUMP) && buttons_i[3*p+2] && buttons_i[3*p]
                            && !dive_used_q[p]) begin
                            state_d[p]     = ST_DIVE;
                            dive_used_d[p] = 1'b1;
                        end else begin
                            state_d[p] = ST_JUMP;
                        end
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_out
        assign action_o[2*g +: 2] = state_q[g];
        assign airborne_o[g]      = (state_q[g] == ST_JUMP) || (state_q[g] == ST_DIVE);
    end

`ifdef ACTION_STATS_EN
    logic [7:0] jcnt_q [NUM_PLAYERS];

    // Saturating count of accepted jumps; dives and refused presses never reach jump_acc.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                jcnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (jump_acc[p] && (jcnt_q[p] != 8'hFF)) begin
                    jcnt_q[p] <= jcnt_q[p] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_stats
        assign jump_count_o[8*g +: 8] = jcnt_q[g];
    end
`endif

endmodule
